// File: rtl/int_to_fp_seq.sv
// Iterative unsigned (optionally signed) integer to IEEE-754 single converter with optional x/(2^IN_W-1) normalisation.
// Optional feature macro: INT2FP_SIGNED_EN (two's complement input, sign carried to fp_out[31]).
module int_to_fp_seq #(
  parameter int unsigned IN_W = 8
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] int_in,
  input  logic            norm_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     fp_out
);

  localparam int unsigned TERMS = (32 + IN_W - 1) / IN_W;
  localparam int unsigned ACC_W = 33;
  localparam int unsigned LZ_W  = 5;
  localparam int unsigned E_W   = 8;
  localparam int unsigned CNT_W = $clog2(TERMS + 1);
  localparam int unsigned ALIGN = 32 - IN_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IN_W-1:0]  m_q, m_d;
  logic [LZ_W-1:0]  lz_q, lz_d;
  logic             norm_q, norm_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] term_q, term_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      fp_q, fp_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             sign_c;
  logic [IN_W-1:0]  mag_c;
  logic [ACC_W-1:0] m_aligned_c;
  logic             ovf_c, guard_c, sticky_c, rnd_up_c;
  logic [22:0]      mant_src_c;
  logic [23:0]      rnd_mant_c;
  logic [E_W-1:0]   exp_base_c, rnd_exp_c;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign fp_out    = fp_q;

  // Magnitude and sign are resolved at capture so the datapath stays unsigned.
`ifdef INT2FP_SIGNED_EN
  assign sign_c = int_in[IN_W-1];
  assign mag_c  = sign_c ? (IN_W'(~int_in) + IN_W'(1)) : int_in;
`else
  assign sign_c = 1'b0;
  assign mag_c  = int_in;
`endif

  assign m_aligned_c = ACC_W'(m_q) << ALIGN;

  // RNE rounding of the Q2.31 accumulator; norm mode always has a nonzero dropped tail.
  always_comb begin
    ovf_c      = acc_q[32];
    mant_src_c = ovf_c ? acc_q[31:9] : acc_q[30:8];
    guard_c    = ovf_c ? acc_q[8] : acc_q[7];
    sticky_c   = (ovf_c ? (|acc_q[7:1]) : (|acc_q[6:0])) | norm_q;
    rnd_up_c   = guard_c & (sticky_c | mant_src_c[0]);
    rnd_mant_c = {1'b0, mant_src_c} + 24'(rnd_up_c);
    exp_base_c = norm_q ? E_W'(126) : E_W'(126 + IN_W);
    rnd_exp_c  = exp_base_c - E_W'(lz_q) + E_W'(ovf_c) + E_W'(rnd_mant_c[23]);
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    lz_d    = lz_q;
    norm_d  = norm_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    acc_d   = acc_q;
    term_d  = term_q;
    cnt_d   = cnt_q;
    fp_d    = fp_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          m_d     = mag_c;
          lz_d    = '0;
          cnt_d   = '0;
          norm_d  = norm_in;
          sign_d  = sign_c;
          zero_d  = (mag_c == '0);
          // Zero words still pass through the result register stage.
          state_d = (mag_c == '0) ? S_ROUND : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (m_q[IN_W-1]) begin
          acc_d   = m_aligned_c;
          term_d  = m_aligned_c >> IN_W;
          state_d = norm_q ? S_ACC : S_ROUND;
        end else begin
          m_d  = m_q << 1;
          lz_d = lz_q + LZ_W'(1);
        end
      end
      S_ACC: begin
        acc_d  = acc_q + term_q;
        term_d = term_q >> IN_W;
        if (cnt_q == CNT_W'(TERMS - 2)) begin
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ROUND: begin
        fp_d    = zero_q ? 32'h0 : {sign_q, rnd_exp_c, rnd_mant_c[22:0]};
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      lz_q        <= '0;
      norm_q      <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      term_q      <= '0;
      cnt_q       <= '0;
      fp_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      lz_q        <= lz_d;
      norm_q      <= norm_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
      term_q      <= term_d;
      cnt_q       <= cnt_d;
      fp_q        <= fp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Self-checking bench for int_to_fp_seq: arithmetic reference model, directed literals, sweeps, backpressure, reset abort.
module tb_int_to_fp_seq;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned TERMS = (32 + IN_W - 1) / IN_W;

  logic            clk;
  logic            arst;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] int_in;
  logic            norm_in;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     fp_out;

  int_to_fp_seq #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .int_in    (int_in),
    .norm_in   (norm_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_out    (fp_out)
  );

  typedef struct {
    logic [31:0] fp;
    int          lat;
    int          cap;
    bit          has_lit;
    logic [31:0] lit_fp;
    int          lit_lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          stall_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: exact integer arithmetic, then generic normalise and round to nearest.
  function automatic void model(input logic [IN_W-1:0] x, input bit norm,
                                output logic [31:0] fp, output int lat);
    longint unsigned mag, mm, acc, rem, half, mant;
    bit s;
    int p, lz, t, e;
    s   = 1'b0;
    mag = 64'(x);
`ifdef INT2FP_SIGNED_EN
    if (x[IN_W-1]) begin
      s   = 1'b1;
      mag = (64'd1 << IN_W) - 64'(x);
    end
`endif
    if (mag == 0) begin
      fp  = 32'h0;
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < int'(IN_W); i++) if (((mag >> i) & 64'd1) != 0) p = i;
    lz = int'(IN_W) - 1 - p;
    mm = mag << (31 - p);
    if (norm) begin
      acc = 0;
      for (int k = 0; k < int'(TERMS); k++) acc += mm >> (k * int'(IN_W));
      e   = 126 - lz;
      lat = lz + int'(TERMS) + 1;
    end else begin
      acc = mm;
      e   = 127 + p;
      lat = lz + 2;
    end
    t = 0;
    for (int i = 0; i < 40; i++) if (((acc >> i) & 64'd1) != 0) t = i;
    e    = e + (t - 31);
    mant = acc >> (t - 23);
    rem  = acc & ((64'd1 << (t - 23)) - 64'd1);
    half = 64'd1 << (t - 24);
    if (norm ? (rem >= half) : ((rem > half) || (rem == half && (mant & 64'd1) != 0)))
      mant++;
    if (mant >= (64'd1 << 24)) begin
      mant = mant >> 1;
      e++;
    end
    fp = {s, 8'(e), 23'(mant)};
  endfunction

  task automatic send(input logic [IN_W-1:0] x, input bit norm, input bit has_lit,
                      input logic [31:0] lit_fp, input int lit_lat);
    exp_t e;
    int   budget;
    in_valid = 1'b1;
    int_in   = x;
    norm_in  = norm;
    budget   = 0;
    while (!in_ready && budget < 200) begin
      @(posedge clk); #2;
      budget++;
    end
    if (!in_ready) begin
      check(1'b0, "accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    model(x, norm, e.fp, e.lat);
    e.cap     = cyc + 1;
    e.has_lit = has_lit;
    e.lit_fp  = lit_fp;
    e.lit_lat = lit_lat;
    exp_q.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 500) begin
      @(posedge clk); #2;
      budget++;
    end
    check(exp_q.size() == 0 && !out_valid, "drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Compare process: every output beat against the model, plus hold and handshake rules.
  bit          prev_ov;
  bit          prev_beat;
  logic [31:0] held_fp;
  exp_t        cur;
  int          lat_act;

  always @(negedge clk) begin
    if (!arst) begin
      prev_ov   = 1'b0;
      prev_beat = 1'b0;
    end else begin
      if (prev_beat)
        check(in_ready && !out_valid, "ready_after_beat", {30'd0, in_ready, out_valid}, 32'd2);
      if (out_valid) begin
        if (!prev_ov) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_out", fp_out, 32'h0);
          end else begin
            cur     = exp_q.pop_front();
            lat_act = cyc - cur.cap;
            check(fp_out == cur.fp, "fp_model", fp_out, cur.fp);
            check(lat_act == cur.lat, "latency_model", 32'(lat_act), 32'(cur.lat));
            if (cur.has_lit) begin
              check(fp_out == cur.lit_fp, "fp_literal", fp_out, cur.lit_fp);
              check(lat_act == cur.lit_lat, "latency_literal", 32'(lat_act), 32'(cur.lit_lat));
            end
          end
          held_fp = fp_out;
        end else begin
          check(fp_out == held_fp, "fp_stable", fp_out, held_fp);
        end
        check(!in_ready, "busy_not_ready", 32'(in_ready), 32'd0);
      end
      prev_beat = out_valid && out_ready;
      prev_ov   = out_valid;
    end
  end

  initial begin
    logic [31:0] mfp;
    int          mlat;
    arst       = 1'b0;
    in_valid   = 1'b0;
    int_in     = '0;
    norm_in    = 1'b0;
    out_ready  = 1'b1;
    stall_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'd1);
    check(out_valid == 1'b0, "reset_out_valid", 32'(out_valid), 32'd0);
    check(fp_out == 32'h0, "reset_fp_out", fp_out, 32'h0);
    @(posedge clk); #5;
    arst = 1'b1;
    @(posedge clk); #2;

    // Model pins against hand-derived values.
    model(IN_W'(1), 1'b1, mfp, mlat);
    check(mfp == 32'h3B808081, "model_pin_norm1", mfp, 32'h3B808081);
    check(mlat == 12, "model_pin_norm1_lat", 32'(mlat), 32'd12);
    model(IN_W'(0), 1'b1, mfp, mlat);
    check(mfp == 32'h0 && mlat == 1, "model_pin_zero", mfp, 32'h0);

    // Directed literals.
`ifdef INT2FP_SIGNED_EN
    send(IN_W'(8'h00), 1'b0, 1'b1, 32'h00000000, 1);
    send(IN_W'(8'h80), 1'b0, 1'b1, 32'hC3000000, 2);
    send(IN_W'(8'hFF), 1'b0, 1'b1, 32'hBF800000, 9);
    send(IN_W'(8'h7F), 1'b0, 1'b1, 32'h42FE0000, 3);
    send(IN_W'(8'h01), 1'b1, 1'b1, 32'h3B808081, 12);
    model(IN_W'(8'h81), 1'b1, mfp, mlat);
    check(mfp[31] == 1'b1, "model_pin_neg_norm_sign", {31'd0, mfp[31]}, 32'd1);
    send(IN_W'(8'h81), 1'b1, 1'b0, 32'h0, 0);
`else
    send(IN_W'(0),   1'b0, 1'b1, 32'h00000000, 1);
    send(IN_W'(1),   1'b0, 1'b1, 32'h3F800000, 9);
    send(IN_W'(255), 1'b0, 1'b1, 32'h437F0000, 2);
    send(IN_W'(128), 1'b0, 1'b1, 32'h43000000, 2);
    send(IN_W'(1),   1'b1, 1'b1, 32'h3B808081, 12);
    send(IN_W'(255), 1'b1, 1'b1, 32'h3F800000, 5);
    send(IN_W'(128), 1'b1, 1'b1, 32'h3F008081, 5);
`endif
    drain();

    // Exhaustive sweep in both modes.
    for (int md = 0; md < 2; md++)
      for (int v = 0; v < (1 << IN_W); v++)
        send(IN_W'(v), md[0], 1'b0, 32'h0, 0);
    drain();

    // Backpressure with changing inputs while the result is held.
    out_ready = 1'b0;
    send(IN_W'(200), 1'b0, 1'b0, 32'h0, 0);
    for (int b = 0; b < 100 && !out_valid; b++) begin
      @(posedge clk); #2;
    end
    check(out_valid, "bp_result_ready", 32'(out_valid), 32'd1);
    repeat (5) begin
      in_valid = 1'b1;
      int_in   = IN_W'($urandom);
      norm_in  = 1'($urandom);
      @(posedge clk); #2;
      check(!in_ready && out_valid, "bp_hold", {30'd0, in_ready, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    check(!out_valid && in_ready, "bp_release", {30'd0, in_ready, out_valid}, 32'd2);
    repeat (20) @(posedge clk);
    #2;
    check(exp_q.size() == 0 && !out_valid, "bp_no_extra", 32'(exp_q.size()), 32'd0);

    // Reset abort while accumulating series terms.
    send(IN_W'(1), 1'b1, 1'b0, 32'h0, 0);
    repeat (8) @(posedge clk);
    #2;
    arst = 1'b0;
    exp_q.delete();
    #1;
    check(!out_valid, "abort_out_valid", 32'(out_valid), 32'd0);
    check(in_ready, "abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #5;
    arst = 1'b1;
    @(posedge clk); #2;
`ifdef INT2FP_SIGNED_EN
    send(IN_W'(8'hFF), 1'b0, 1'b1, 32'hBF800000, 9);
`else
    send(IN_W'(255), 1'b0, 1'b1, 32'h437F0000, 2);
`endif
    drain();

    // Back-to-back random stream, consumer always ready.
    for (int i = 0; i < 300; i++)
      send(IN_W'($urandom), 1'($urandom), 1'b0, 32'h0, 0);
    drain();

    // Random stream with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 100; i++)
          send(IN_W'($urandom), 1'($urandom), 1'b0, 32'h0, 0);
        stall_done = 1'b1;
      end
      begin
        while (!stall_done) begin
          @(posedge clk); #2;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
